tt_sweep_capture: RTL

- Sequential stimulus-and-capture stage placed around a 3-input combinational gate block. It drives that block's a, b, c inputs and consumes its z output.
- On start, it steps a,b,c through all 8 combinations, 000 to 111, with a as MSB, and holds each vector for HOLD_CYCLES clocks.
- It samples z at the end of each hold window and assembles the 8-bit truth table.
- It then compares the table against EXPECTED and reports pass or fail, plus the index of the first failing minterm.

---
 rtl/tt_sweep_capture.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: exhaustive stimulus-and-capture stage for a 3-input gate.
// Steps {a,b,c} through 000..111, holds each vector HOLD_CYCLES clocks,
// samples z on the last edge of each window, then compares the captured
// truth table against EXPECTED and reports pass / first failing minterm.
module tt_sweep_capture #(
   parameter int          HOLD_CYCLES = 10,
   parameter logic [7:0]  EXPECTED    = 8'b1110_1000,
   parameter int          CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       z,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic [7:0] truth_table,
   output logic       pass,
   output logic [2:0] fail_idx,
   output logic       fail_valid
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Terminal count of the hold counter: z is sampled when cnt reaches it.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

   state_t            state_q, state_d;
   logic [2:0]        idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [7:0]        tt_q, tt_d;
   logic              pass_q, pass_d;
   logic [2:0]        fail_idx_q, fail_idx_d;
   logic              fail_valid_q, fail_valid_d;

   logic              last_cnt;
   logic              last_vec;
   logic [7:0]        merged;
   logic [7:0]        diff;
   logic [2:0]        first_diff;

   assign last_cnt = (cnt_q == CNT_LAST);
   assign last_vec = (idx_q == 3'd7);

   // The final compare must include the bit being sampled this edge, which
   // is not yet in tt_q.
   assign merged = {z, tt_q[6:0]};
   assign diff   = merged ^ EXPECTED;

   // Priority encoder: lowest mismatching minterm (0 when there is none).
   always_comb begin
      first_diff = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (diff[i]) begin
            first_diff = 3'(i);
         end
      end
   end

   // State and datapath registers, asynchronously cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= 3'd0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         tt_q         <= 8'd0;
         pass_q       <= 1'b0;
         fail_idx_q   <= 3'd0;
         fail_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         tt_q         <= tt_d;
         pass_q       <= pass_d;
         fail_idx_q   <= fail_idx_d;
         fail_valid_q <= fail_valid_d;
      end
   end

   // Next-state logic: abort outranks the end-of-sweep transition.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (last_cnt && last_vec) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath / output next values: stepping, sampling and final compare.
   always_comb begin
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      tt_d         = tt_q;
      pass_d       = pass_q;
      fail_idx_d   = fail_idx_q;
      fail_valid_d = fail_valid_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d        = 3'd0;
               cnt_d        = '0;
               busy_d       = 1'b1;
               tt_d         = 8'd0;
               pass_d       = 1'b0;
               fail_idx_d   = 3'd0;
               fail_valid_d = 1'b0;
            end
         end
         S_RUN: begin
            if (abort) begin
               // Partial capture is kept for inspection; no verdict given.
               idx_d  = 3'd0;
               cnt_d  = '0;
               busy_d = 1'b0;
               pass_d = 1'b0;
            end else if (last_cnt) begin
               tt_d[idx_q] = z;
               cnt_d       = '0;
               if (last_vec) begin
                  idx_d        = 3'd0;
                  busy_d       = 1'b0;
                  done_d       = 1'b1;
                  pass_d       = (merged == EXPECTED);
                  fail_valid_d = |diff;
                  fail_idx_d   = first_diff;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // All outputs come straight from flops.
   assign a           = idx_q[2];
   assign b           = idx_q[1];
   assign c           = idx_q[0];
   assign busy        = busy_q;
   assign done        = done_q;
   assign truth_table = tt_q;
   assign pass        = pass_q;
   assign fail_idx    = fail_idx_q;
   assign fail_valid  = fail_valid_q;

endmodule
